// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill engine.
// Contents: FSM state encoding, block geometry constants and the block-alignment mask.
package cache_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } fill_state_e;

  localparam int unsigned BLOCK_WORDS   = 8;
  localparam int unsigned BLOCK_BYTES   = 16;
  localparam int unsigned OFFSET_BITS   = 4;
  localparam int unsigned WORD_SEL_BITS = 3;
  localparam logic [15:0] BLOCK_MASK    = 16'hFFF0;

endpackage

// File: rtl/fill_counter.sv
// Small up-counter used for the issue and receive sides of a block fill.
// Ports:
//   clk      - system clock, rising edge
//   clear    - synchronous clear (wins over enable)
//   enable   - count up by one this cycle
//   count    - current count
//   terminal - high while count equals TERMINAL
module fill_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling engine: on a cache miss, fetches the whole block from pipelined memory,
// writes each returned word into the data array and writes the tag with the last word.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   miss_detected, miss_address  - miss request from the cache (byte address)
//   fsm_busy                     - fill in progress (also high in the accepting cycle)
//   mem_read, memory_address     - one read strobe per issued word address
//   memory_data_valid/_data      - returned words, in issue order
//   write_data_array, cache_word_sel, cache_data - data array write port
//   write_tag_array              - tag/valid write, pulsed with the last word
// Optional build macro CACHE_FILL_PERF_EN adds saturating miss_count and fill_cycles outputs.
module cache_fill_fsm #(
  parameter int unsigned AWIDTH      = 16,
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [AWIDTH-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           mem_read,
  output logic [AWIDTH-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [DWIDTH-1:0]              memory_data,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_sel,
  output logic [DWIDTH-1:0]              cache_data
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]                    miss_count,
  output logic [15:0]                    fill_cycles
`endif
);

  import cache_pkg::*;

  localparam int unsigned SEL_W = $clog2(BLOCK_WORDS);
  // Byte offset inside a block: word select plus the byte-in-word bit.
  localparam int unsigned OFF_W = SEL_W + 1;

  fill_state_e       state;
  logic [AWIDTH-1:0] base;
  logic [SEL_W:0]    issue_cnt;
  logic [SEL_W:0]    recv_cnt;
  logic              issue_done;
  logic              recv_last;
  logic              in_fill;
  logic              accept;
  logic              last_word;
  logic              cnt_clear;
  logic [SEL_W-1:0]  issue_sel;

  assign in_fill   = (state == StFill);
  assign accept    = (state == StIdle) && miss_detected;
  assign last_word = in_fill && memory_data_valid && recv_last;
  // Counters sit at zero whenever idle, so an accepted miss always starts from zero.
  assign cnt_clear = rst || !in_fill;

  fill_counter #(
    .WIDTH    (SEL_W + 1),
    .TERMINAL (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk      (clk),
    .clear    (cnt_clear),
    .enable   (in_fill && !issue_done),
    .count    (issue_cnt),
    .terminal (issue_done)
  );

  fill_counter #(
    .WIDTH    (SEL_W + 1),
    .TERMINAL (BLOCK_WORDS - 1)
  ) u_recv_cnt (
    .clk      (clk),
    .clear    (cnt_clear),
    .enable   (in_fill && memory_data_valid),
    .count    (recv_cnt),
    .terminal (recv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      base  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (miss_detected) begin
            state <= StFill;
            base  <= {miss_address[AWIDTH-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        StFill: begin
          // Misses seen during a fill are dropped; the cache re-asserts them afterwards.
          if (last_word) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // After the last issue the address holds the final word of the block.
  assign issue_sel = issue_done ? {SEL_W{1'b1}} : SEL_W'(issue_cnt);

  always_comb begin
    fsm_busy         = in_fill || accept;
    mem_read         = in_fill && !issue_done;
    memory_address   = '0;
    if (in_fill) begin
      memory_address = base + (AWIDTH'(issue_sel) << 1);
    end
    write_data_array = in_fill && memory_data_valid;
    write_tag_array  = last_word;
    cache_word_sel   = write_data_array ? SEL_W'(recv_cnt) : '0;
    cache_data       = write_data_array ? memory_data : '0;
  end

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count  <= '0;
      fill_cycles <= '0;
    end else begin
      if (accept && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
      if (in_fill && (fill_cycles != 16'hFFFF)) begin
        fill_cycles <= fill_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
